stereo_pan_router: RTL



---
 rtl/stereo_pan_router.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/stereo_pan_router.sv
// Mono-to-stereo output stage: pan-controlled, click-free gain ramp,
// two-stage multiply/format pipeline and codec underrun counter.
module stereo_pan_router #(
    parameter int RAMP_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] sample_in,
    input  logic        in_ready,
    input  logic        pan_left,
    input  logic        pan_right,
    input  logic        pan_center,
    input  logic        new_frame,
    output logic [23:0] hphone_l,
    output logic [23:0] hphone_r,
    output logic        out_ready,
    output logic [3:0]  pan_pos,
    output logic        ramping,
    output logic [7:0]  underrun_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RAMP = 1'b1;
    localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

    logic [3:0]    pan_q, pan_d;
    logic [4:0]    gl_q, gl_d, gr_q, gr_d;
    logic [4:0]    tgt_l, tgt_r;
    logic [0:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          match;

    logic          v1_q;
    logic [20:0]   pl_q, pr_q;
    logic signed [20:0] pl_d, pr_d;
    logic [23:0]   hl_q, hr_q;
    logic          rdy_q;
    logic          fresh_q, fresh_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          unused_bits;

    function automatic logic [4:0] step(input logic [4:0] g, input logic [4:0] t);
        if (g < t)      return g + 5'd1;
        else if (g > t) return g - 5'd1;
        else            return g;
    endfunction

    always_comb begin
        pan_d = pan_q;
        if (pan_center)
            pan_d = 4'd4;
        else if (pan_left && !pan_right) begin
            if (pan_q != 4'd0) pan_d = pan_q - 4'd1;
        end else if (pan_right && !pan_left) begin
            if (pan_q != 4'd8) pan_d = pan_q + 4'd1;
        end
    end

    assign tgt_r = {pan_q, 1'b0};
    assign tgt_l = 5'd16 - tgt_r;
    assign match = (gl_q == tgt_l) && (gr_q == tgt_r);

    // Gains step on the divider wrap; a retarget mid-ramp keeps the divider.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gl_d    = gl_q;
        gr_d    = gr_q;
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (!match) state_d = RAMP;
            end
            default: begin
                if (match) state_d = IDLE;
                if (in_ready) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        gl_d  = step(gl_q, tgt_l);
                        gr_d  = step(gr_q, tgt_r);
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
            end
        endcase
    end

    assign pl_d = $signed({{5{sample_in[15]}}, sample_in}) * $signed({16'd0, gl_q});
    assign pr_d = $signed({{5{sample_in[15]}}, sample_in}) * $signed({16'd0, gr_q});

    // A frame coinciding with a new output counts as fresh but consumes it.
    always_comb begin
        fresh_d = fresh_q;
        cnt_d   = cnt_q;
        if (new_frame) begin
            fresh_d = 1'b0;
            if (!fresh_q && !rdy_q && cnt_q != 8'hFF)
                cnt_d = cnt_q + 8'd1;
        end else if (rdy_q) begin
            fresh_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pan_q   <= 4'd4;
            gl_q    <= 5'd8;
            gr_q    <= 5'd8;
            state_q <= IDLE;
            div_q   <= '0;
            v1_q    <= 1'b0;
            pl_q    <= '0;
            pr_q    <= '0;
            hl_q    <= '0;
            hr_q    <= '0;
            rdy_q   <= 1'b0;
            fresh_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pan_q   <= pan_d;
            gl_q    <= gl_d;
            gr_q    <= gr_d;
            state_q <= state_d;
            div_q   <= div_d;
            v1_q    <= in_ready;
            if (in_ready) begin
                pl_q <= pl_d;
                pr_q <= pr_d;
            end
            rdy_q <= v1_q;
            if (v1_q) begin
                hl_q <= {pl_q[19:4], 8'h00};
                hr_q <= {pr_q[19:4], 8'h00};
            end
            fresh_q <= fresh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign unused_bits  = ^{pl_q[20], pl_q[3:0], pr_q[20], pr_q[3:0]};
    assign hphone_l     = hl_q;
    assign hphone_r     = hr_q;
    assign out_ready    = rdy_q;
    assign pan_pos      = pan_q;
    assign ramping      = (state_q == RAMP);
    assign underrun_cnt = cnt_q;

endmodule
